load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port req_valid, input, 1: execute stage presents a memory request.
REQ-004 SHALL have port req_ready, output, 1: unit can accept a request this cycle.
REQ-005 SHALL have port req_is_store, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port funct3, input, 3: RV32I width/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-007 SHALL have port base_addr, input, 32: rs1 value.
REQ-008 SHALL have port offset, input, 12: signed immediate.
REQ-009 SHALL have port store_data, input, 32: rs2 value.
REQ-010 SHALL have port Mem_write, output, 1: data-memory write enable.
REQ-011 SHALL have port Load_type, output, 3: data-memory load code.
REQ-012 SHALL have port Store_type, output, 2: data-memory store code.
REQ-013 SHALL have port Address, output, 32: data-memory byte address.
REQ-014 SHALL have port Write_data, output, 32: data-memory write data.
REQ-015 SHALL have port Data_mem_out, input, 32: registered data-memory read data, valid the cycle after the memory samples Address.
REQ-016 SHALL have port resp_valid, output, 1: response available.
REQ-017 SHALL have port resp_ready, input, 1: writeback accepts the response.
REQ-018 SHALL have port resp_data, output, 32: load result; 0 for stores and errors.
REQ-019 SHALL have port resp_err, output, 1: misaligned, out-of-range or illegal funct3.

Function
REQ-020 SHALL implement states IDLE, ACCESS, CAPTURE, RESP; req_ready = 1 only in IDLE.
REQ-021 SHALL accept a request on a posedge where state = IDLE and req_valid = 1, and register the effective address EA = base_addr + sign-extended offset, modulo 2^32.
REQ-022 SHALL map load funct3 000/001/010/100/101 to Load_type 0/1/2/3/4, and store funct3 000/001/010 to Store_type 0/1/2; any other funct3 is illegal.
REQ-023 SHALL flag misalignment for halfword accesses with EA[0] = 1 and for word accesses with EA[1:0] != 0.
REQ-024 SHALL flag out-of-range for: LB/LBU with EA > 255; LH/LHU with EA > 254; LW with EA > 252; any store with EA > 252, because the memory writes 4 bytes for every store width.
REQ-025 On accepting an erroneous request, SHALL go IDLE -> RESP directly with resp_err = 1 and resp_data = 0, and SHALL NOT assert Mem_write.
REQ-026 On accepting a legal request, SHALL go IDLE -> ACCESS and register Address = EA, Write_data = store_data, Load_type and Store_type in the same edge.
REQ-027 For a store, SHALL assert Mem_write = 1 for exactly the ACCESS cycle, then go ACCESS -> RESP.
REQ-028 For a load, SHALL keep Mem_write = 0 and go ACCESS -> CAPTURE; in CAPTURE it SHALL latch Data_mem_out into resp_data, then go CAPTURE -> RESP.
REQ-029 In RESP, SHALL assert resp_valid = 1 with resp_data and resp_err held stable until resp_ready = 1; return to IDLE on that edge.
REQ-030 Latencies from the accept edge to first resp_valid: load 3 cycles, store 2 cycles, error 1 cycle.
REQ-031 SHALL hold Address, Write_data, Load_type and Store_type stable from the accept edge until the next accept, so the combinational memory write never sees changing inputs while Mem_write = 1.
REQ-032 SHALL hold Mem_write = 0 in every state except ACCESS-with-store.
REQ-033 SHALL ignore req_valid outside IDLE; a request is never lost, because req_ready = 0 outside IDLE.

Reset
REQ-034 With reset = 1 at a posedge, state SHALL become IDLE and the outputs SHALL be: Mem_write = 0, resp_valid = 0, resp_err = 0, resp_data = 0, Address = 0, Write_data = 0, Load_type = 0, Store_type = 0, req_ready = 1.
REQ-035 Reset mid-operation, including during an ACCESS store cycle, SHALL drop Mem_write on that edge and discard the pending response; reset has priority over all transitions.

Verification
REQ-036 SW with base = 0x10, offset = 4, data = 0xDEADBEEF -> Mem_write high for exactly one cycle with Address = 0x14 and Store_type = 2; resp_valid 2 cycles after accept, resp_err = 0.
REQ-037 Preload byte[0x14..0x17] = EF BE AD DE, then LW at EA = 0x14 -> resp_data = 0xDEADBEEF, 3 cycles after accept; LBU at EA = 0x14 -> resp_data = 0x000000EF.
REQ-038 LH at EA = 0x21, SW at EA = 0xFD, LB at EA = 0x100, load funct3 = 011 -> each gives resp_err = 1, resp_data = 0, Mem_write never asserted, latency 1 cycle; LB at EA = 0xFF -> resp_err = 0.
REQ-039 base = 0x00000002, offset = 0xFFE (-2) -> Address = 0x00000000 with no error; base = 0, offset = 0xFFF -> EA = 0xFFFFFFFF, out-of-range error.
REQ-040 Hold resp_ready = 0 for 4 cycles in RESP -> resp_valid and resp_data stable, req_ready = 0, new req_valid ignored; resp_ready = 1 -> IDLE next cycle.
REQ-041 Assert reset during the ACCESS cycle of a store -> Mem_write = 0 and resp_valid = 0 after the edge, state IDLE, req_ready = 1.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: computes the effective address, checks alignment and range,
// drives a registered data memory and returns one response per request.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base_addr,
    input  logic [11:0] offset,
    input  logic [31:0] store_data,
    output logic        Mem_write,
    output logic [2:0]  Load_type,
    output logic [1:0]  Store_type,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Data_mem_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ltype_q, ltype_d;
    logic [1:0]  stype_q, stype_d;
    logic        is_store_q, is_store_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] ea;
    logic [1:0]  size;
    logic        illegal;
    logic [2:0]  dec_ltype;
    logic [1:0]  dec_stype;
    logic [31:0] limit;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;

    assign ea = base_addr + {{20{offset[11]}}, offset};

    // size: 0 byte, 1 halfword, 2 word
    always_comb begin
        size      = 2'd0;
        illegal   = 1'b0;
        dec_ltype = 3'd0;
        dec_stype = 2'd0;
        if (req_is_store) begin
            case (funct3)
                3'b000:  begin size = 2'd0; dec_stype = 2'd0; end
                3'b001:  begin size = 2'd1; dec_stype = 2'd1; end
                3'b010:  begin size = 2'd2; dec_stype = 2'd2; end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000:  begin size = 2'd0; dec_ltype = 3'd0; end
                3'b001:  begin size = 2'd1; dec_ltype = 3'd1; end
                3'b010:  begin size = 2'd2; dec_ltype = 3'd2; end
                3'b100:  begin size = 2'd0; dec_ltype = 3'd3; end
                3'b101:  begin size = 2'd1; dec_ltype = 3'd4; end
                default: illegal = 1'b1;
            endcase
        end
    end

    // The memory always writes four bytes, so every store width is bounded like a word.
    always_comb begin
        if (req_is_store || size == 2'd2) limit = 32'd252;
        else if (size == 2'd1)            limit = 32'd254;
        else                              limit = 32'd255;
    end

    assign misaligned   = (size == 2'd1 && ea[0]) || (size == 2'd2 && ea[1:0] != 2'b00);
    assign out_of_range = ea > limit;
    assign req_err      = illegal || misaligned || out_of_range;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ltype_d     = ltype_q;
        stype_d     = stype_q;
        is_store_d  = is_store_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    resp_data_d = '0;
                    resp_err_d  = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else begin
                        state_d    = S_ACCESS;
                        addr_d     = ea;
                        wdata_d    = store_data;
                        ltype_d    = dec_ltype;
                        stype_d    = dec_stype;
                        is_store_d = req_is_store;
                    end
                end
            end
            S_ACCESS:  state_d = is_store_q ? S_RESP : S_CAPTURE;
            S_CAPTURE: begin
                resp_data_d = Data_mem_out;
                state_d     = S_RESP;
            end
            S_RESP:    if (resp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            ltype_q     <= '0;
            stype_q     <= '0;
            is_store_q  <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ltype_q     <= ltype_d;
            stype_q     <= stype_d;
            is_store_q  <= is_store_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign Mem_write  = (state_q == S_ACCESS) && is_store_q;
    assign resp_valid = (state_q == S_RESP);
    assign Address    = addr_q;
    assign Write_data = wdata_q;
    assign Load_type  = ltype_q;
    assign Store_type = stype_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a 256-byte registered data memory model and
// a scoreboard of expected responses.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  funct3;
    logic [31:0] base_addr;
    logic [11:0] offset;
    logic [31:0] store_data;
    logic        Mem_write;
    logic [2:0]  Load_type;
    logic [1:0]  Store_type;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Data_mem_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          mw;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          mw_cnt;
        logic [31:0] mw_addr;
        logic [1:0]  mw_stype;
        logic [31:0] addr;
    } obs_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [7:0] mem [0:255];

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .funct3(funct3),
        .base_addr(base_addr), .offset(offset), .store_data(store_data),
        .Mem_write(Mem_write), .Load_type(Load_type), .Store_type(Store_type),
        .Address(Address), .Write_data(Write_data), .Data_mem_out(Data_mem_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [7:0] a, input logic [2:0] lt);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a];
        b1 = mem[a + 8'd1];
        b2 = mem[a + 8'd2];
        b3 = mem[a + 8'd3];
        case (lt)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd2:    return {b3, b2, b1, b0};
            3'd3:    return {24'd0, b0};
            3'd4:    return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    // Registered read, combinational-style write on the same edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (Mem_write) begin
            mem[Address[7:0]] <= Write_data[7:0];
            if (Store_type != 2'd0) mem[Address[7:0] + 8'd1] <= Write_data[15:8];
            if (Store_type == 2'd2) begin
                mem[Address[7:0] + 8'd2] <= Write_data[23:16];
                mem[Address[7:0] + 8'd3] <= Write_data[31:24];
            end
        end
        Data_mem_out <= mem_read(Address[7:0], Load_type);
    end

    // Reference model in terms of bytes touched rather than address limits.
    function automatic exp_t model(input logic st, input logic [2:0] f3,
                                   input logic [31:0] base, input logic [11:0] off);
        exp_t        e;
        logic [31:0] ea;
        int          nb;
        longint      last;
        logic [7:0]  b0, b1, b2, b3;
        ea = base + {{20{off[11]}}, off};
        nb = 0;
        if (st) begin
            case (f3)
                3'b000: nb = 1;
                3'b001: nb = 2;
                3'b010: nb = 4;
                default: nb = 0;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b100: nb = 1;
                3'b001, 3'b101: nb = 2;
                3'b010:         nb = 4;
                default:        nb = 0;
            endcase
        end
        last = longint'(ea) + longint'(st ? 3 : nb - 1);
        e.data = 32'd0; e.err = 1'b0; e.lat = 0; e.mw = 0;
        if (nb == 0 || (ea & 32'(nb - 1)) != 32'd0 || last > 255) begin
            e.err = 1'b1; e.lat = 1;
        end else if (st) begin
            e.lat = 2; e.mw = 1;
        end else begin
            b0 = mem[ea[7:0]];
            b1 = mem[ea[7:0] + 8'd1];
            b2 = mem[ea[7:0] + 8'd2];
            b3 = mem[ea[7:0] + 8'd3];
            case (f3)
                3'b000:  e.data = {{24{b0[7]}}, b0};
                3'b001:  e.data = {{16{b1[7]}}, b1, b0};
                3'b010:  e.data = {b3, b2, b1, b0};
                3'b100:  e.data = {24'd0, b0};
                default: e.data = {16'd0, b1, b0};
            endcase
            e.lat = 3;
        end
        return e;
    endfunction

    // Drives one request, observes up to the response and completes the handshake.
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                           input logic [11:0] off, input logic [31:0] data, output obs_t o);
        o.data = 'x; o.err = 1'bx; o.lat = 0; o.mw_cnt = 0;
        o.mw_addr = 'x; o.mw_stype = 'x; o.addr = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; funct3 = f3;
        base_addr = base; offset = off; store_data = data;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) o.addr = Address;
            if (Mem_write) begin
                o.mw_cnt++;
                o.mw_addr = Address;
                o.mw_stype = Store_type;
            end
            if (resp_valid) begin
                o.lat = i; o.data = resp_data; o.err = resp_err;
                break;
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (Mem_write !== 1'b0)   begin errors++; $display("FAIL reset_mem_write got=%b want=0", Mem_write); end
        checks++; if (resp_valid !== 1'b0)  begin errors++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        checks++; if (resp_err !== 1'b0)    begin errors++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
        checks++; if (resp_data !== 32'd0)  begin errors++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
        checks++; if (Address !== 32'd0)    begin errors++; $display("FAIL reset_address got=%h want=0", Address); end
        checks++; if (Write_data !== 32'd0) begin errors++; $display("FAIL reset_write_data got=%h want=0", Write_data); end
        checks++; if (Load_type !== 3'd0)   begin errors++; $display("FAIL reset_load_type got=%0d want=0", Load_type); end
        checks++; if (Store_type !== 2'd0)  begin errors++; $display("FAIL reset_store_type got=%0d want=0", Store_type); end
        checks++; if (req_ready !== 1'b1)   begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        reset = 1'b0;
    endtask

    task automatic test_store();
        obs_t o;
        exp_t e;
        exp_q.push_back(model(1'b1, 3'b010, 32'h10, 12'd4));
        run_req(1'b1, 3'b010, 32'h10, 12'd4, 32'hDEADBEEF, o);
        e = exp_q.pop_front();
        checks++; if (o.mw_cnt !== 1)          begin errors++; $display("FAIL sw_mw_cycles got=%0d want=1", o.mw_cnt); end
        checks++; if (o.mw_addr !== 32'h14)    begin errors++; $display("FAIL sw_address got=%h want=00000014", o.mw_addr); end
        checks++; if (o.mw_stype !== 2'd2)     begin errors++; $display("FAIL sw_store_type got=%0d want=2", o.mw_stype); end
        checks++; if (o.lat !== e.lat)         begin errors++; $display("FAIL sw_latency got=%0d want=%0d", o.lat, e.lat); end
        checks++; if (o.err !== 1'b0)          begin errors++; $display("FAIL sw_err got=%b want=0", o.err); end
        checks++; if (o.data !== 32'd0)        begin errors++; $display("FAIL sw_data got=%h want=0", o.data); end
    endtask

    task automatic test_load();
        obs_t o;
        exp_t e;
        exp_q.push_back(model(1'b0, 3'b010, 32'h14, 12'd0));
        run_req(1'b0, 3'b010, 32'h14, 12'd0, 32'd0, o);
        e = exp_q.pop_front();
        checks++; if (o.data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h want=deadbeef", o.data); end
        checks++; if (o.lat !== 3)             begin errors++; $display("FAIL lw_latency got=%0d want=3", o.lat); end
        checks++; if (o.err !== e.err)         begin errors++; $display("FAIL lw_err got=%b want=%b", o.err, e.err); end
        checks++; if (o.mw_cnt !== 0)          begin errors++; $display("FAIL lw_mem_write got=%0d want=0", o.mw_cnt); end
        exp_q.push_back(model(1'b0, 3'b100, 32'h10, 12'd4));
        run_req(1'b0, 3'b100, 32'h10, 12'd4, 32'd0, o);
        e = exp_q.pop_front();
        checks++; if (o.data !== 32'h000000EF) begin errors++; $display("FAIL lbu_data got=%h want=000000ef", o.data); end
        checks++; if (o.lat !== e.lat)         begin errors++; $display("FAIL lbu_latency got=%0d want=%0d", o.lat, e.lat); end
    endtask

    task automatic test_errors();
        logic        st   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3   [6] = '{3'b001, 3'b010, 3'b000, 3'b011, 3'b000, 3'b000};
        logic [31:0] base [6] = '{32'h21, 32'hFD, 32'h100, 32'h0, 32'hFF, 32'h0};
        logic [11:0] off  [6] = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'hFFF};
        logic        werr [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        obs_t o;
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(model(st[k], f3[k], base[k], off[k]));
            run_req(st[k], f3[k], base[k], off[k], 32'hA5A5A5A5, o);
            e = exp_q.pop_front();
            checks++; if (o.err !== werr[k]) begin errors++; $display("FAIL err_case%0d_err got=%b want=%b", k, o.err, werr[k]); end
            checks++; if (o.data !== e.data) begin errors++; $display("FAIL err_case%0d_data got=%h want=%h", k, o.data, e.data); end
            checks++; if (o.lat !== e.lat)   begin errors++; $display("FAIL err_case%0d_latency got=%0d want=%0d", k, o.lat, e.lat); end
            checks++; if (o.mw_cnt !== 0)    begin errors++; $display("FAIL err_case%0d_mem_write got=%0d want=0", k, o.mw_cnt); end
        end
    endtask

    task automatic test_wrap();
        obs_t o;
        exp_t e;
        exp_q.push_back(model(1'b0, 3'b000, 32'h2, 12'hFFE));
        run_req(1'b0, 3'b000, 32'h2, 12'hFFE, 32'd0, o);
        e = exp_q.pop_front();
        checks++; if (o.addr !== 32'h0)  begin errors++; $display("FAIL wrap_address got=%h want=00000000", o.addr); end
        checks++; if (o.err !== 1'b0)    begin errors++; $display("FAIL wrap_err got=%b want=0", o.err); end
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL wrap_data got=%h want=%h", o.data, e.data); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   waited;
        exp_q.push_back(model(1'b0, 3'b010, 32'h14, 12'd0));
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; funct3 = 3'b010; base_addr = 32'h14; offset = 12'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        waited = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            waited = i;
            if (resp_valid) break;
        end
        e = exp_q.pop_front();
        checks++; if (waited !== e.lat) begin errors++; $display("FAIL bp_latency got=%0d want=%0d", waited, e.lat); end
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_is_store = 1'b1; funct3 = 3'b010; base_addr = 32'h40; store_data = 32'h12345678;
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1)  begin errors++; $display("FAIL bp_resp_valid%0d got=%b want=1", k, resp_valid); end
            checks++; if (resp_data !== e.data) begin errors++; $display("FAIL bp_resp_data%0d got=%h want=%h", k, resp_data, e.data); end
            checks++; if (req_ready !== 1'b0)   begin errors++; $display("FAIL bp_req_ready%0d got=%b want=0", k, req_ready); end
            checks++; if (Mem_write !== 1'b0)   begin errors++; $display("FAIL bp_mem_write%0d got=%b want=0", k, Mem_write); end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b want=0", resp_valid); end
        checks++; if (req_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; funct3 = 3'b010; base_addr = 32'h20; offset = 12'd0;
        store_data = 32'h0BADF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (Mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_access got=%b want=1", Mem_write); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (Mem_write !== 1'b0)  begin errors++; $display("FAIL rstmid_mem_write got=%b want=0", Mem_write); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_resp_valid got=%b want=0", resp_valid); end
        checks++; if (req_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_req_ready got=%b want=1", req_ready); end
        repeat (3) @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_resp got=%b want=0", resp_valid); end
    endtask

    task automatic test_back_to_back();
        obs_t        o;
        exp_t        e;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [11:0] off;
        for (int k = 0; k < 40; k++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            base = 32'($urandom_range(0, 300));
            off  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 8));
            exp_q.push_back(model(st, f3, base, off));
            run_req(st, f3, base, off, $urandom, o);
            e = exp_q.pop_front();
            checks++; if (o.err !== e.err)   begin errors++; $display("FAIL b2b%0d_err got=%b want=%b", k, o.err, e.err); end
            checks++; if (o.data !== e.data) begin errors++; $display("FAIL b2b%0d_data got=%h want=%h", k, o.data, e.data); end
            checks++; if (o.lat !== e.lat)   begin errors++; $display("FAIL b2b%0d_latency got=%0d want=%0d", k, o.lat, e.lat); end
            checks++; if (o.mw_cnt !== e.mw) begin errors++; $display("FAIL b2b%0d_mem_write got=%0d want=%0d", k, o.mw_cnt, e.mw); end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; funct3 = 3'd0;
        base_addr = 32'd0; offset = 12'd0; store_data = 32'd0; resp_ready = 1'b0;
        test_reset();
        test_store();
        test_load();
        test_errors();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
